pwm_capture: RTL and testbench
==============================

// Module: pwm_capture
// PURPOSE
//  Per-channel PWM input-capture stage downstream of the PWM IO pads.
//  Consumes pad read-back bits (pad_pwm_dout) and measures period and high time of each waveform, in clk_i cycles.
//  Used for loop-back self-check of the pwm outputs and for measuring external PWM inputs.
//  Results are published per channel with a one-cycle valid strobe and a sticky overflow flag.
// PARAMETERS
//  NUM_CH       3   number of capture channels (matches pwm channel count)
//  CNT_W        32  width of period/high counters and results
//  SYNC_STAGES  2   input synchroniser depth, >=2
//  FILTER_LEN   4   glitch-filter stability length in cycles, >=1 (used only with PWM_CAPTURE_FILTER_EN)
// PORTS
//  clk_i       in   1               system clock
//  rst_i       in   1               synchronous reset, active-high
//  in_i        in   NUM_CH          asynchronous pad read-back bits
//  enable_i    in   NUM_CH          per-channel capture enable
//  period_o    out  NUM_CH x CNT_W  last measured period, rising edge to rising edge
//  high_o      out  NUM_CH x CNT_W  high time of that same period
//  valid_o     out  NUM_CH          1-cycle strobe, period_o/high_o updated this cycle
//  overflow_o  out  NUM_CH          sticky flag: counter saturated with no rising edge
// BEHAVIOUR
//  Reset: every output is 0, counters are 0, sync flops are 0, FSM is IDLE.
//  Sync: in_i passes through SYNC_STAGES flops. Edges are detected on the synced level s against its registered copy s_d.
//  Per-channel FSM:
//   IDLE  : waits for a rising edge, then goes to HIGH with cnt=1. No result is published (first edge only arms).
//   HIGH  : cnt++ each cycle. On a falling edge: high_q<=cnt, go to LOW.
//   LOW   : cnt++ each cycle. On a rising edge: period_o<=cnt, high_o<=high_q, valid_o=1, overflow_o<=0, cnt<=1, go to HIGH.
//  Counting: cnt saturates at 2^CNT_W-1. On saturation, overflow_o<=1 and the FSM goes to IDLE.
//   This covers static 0%/100% duty and a dead input. period_o/high_o keep their old values.
//  Latency: pad edge -> valid_o is SYNC_STAGES+2 cycles (sync, edge detect, result register).
//  An edge and saturation in the same cycle: the edge wins.
//  enable_i low: the channel is forced to IDLE and cnt=0 on the next edge of clk_i.
//   Results and overflow_o are held. valid_o stays 0.
//  enable_i rising: the channel rearms in IDLE. The first valid comes only after two rising edges.
//  rst_i in mid-measurement: everything returns to reset values in that same clock. The partial measurement is discarded.
//  Channels are fully independent. valid_o strobes on several channels may coincide.
// CONFIGURATION
//  PWM_CAPTURE_FILTER_EN defined:
//   - Each channel inserts a glitch filter after the synchroniser.
//   - The filtered level changes only after the synced input has held its new value for FILTER_LEN consecutive cycles.
//   - Latency grows by FILTER_LEN cycles.
//   - Measured period is unchanged.
//   - Pulses shorter than FILTER_LEN are suppressed.
//  Not defined: no filter. The filtered level equals the synced level, and FILTER_LEN is ignored.
// STRUCTURE
//  pwm_pkg (shared with pwm):
//   - cap_state_e enum {IDLE, HIGH, LOW}
//   - typedef cnt_t = logic [CNT_W-1:0]
//   - localparam CNT_MAX.
//  Sub-module pwm_capture_ch: one channel (sync, optional filter, edge detect, FSM, counters). Generated NUM_CH times.
//  Top level: generate loop and port packing only.
// TESTING
//  1. Drive 32 cycles high / 224 cycles low, repeated, on ch0.
//     -> Capture starts from the 2nd rising edge. Then period_o[0]=256 and high_o[0]=32 every 256 cycles.
//  2. Hold ch1 constant 1 with CNT_W=8 override.
//     -> overflow_o[1]=1 after 255 cycles. valid_o[1] never pulses.
//     -> After waveform 10 high / 20 low starts: overflow clears with the first new valid, period=30, high=10.
//  3. Drop enable_i[2] mid-period, then raise it again.
//     -> No valid during the disable. The first new valid comes after 2 rising edges, and results are correct.
//  4. Assert rst_i during HIGH phase.
//     -> The next cycle has all outputs 0 and FSM IDLE. The next period measures correctly.
//  5. Loop-back with the pwm core: period 255, duty 32/64/5, prescaler 0.
//     -> All three channels report a constant period and high time matching the pwm configuration.
//  6. With PWM_CAPTURE_FILTER_EN, FILTER_LEN=4: inject 2-cycle glitches.
//     -> Measurements are unchanged. Without the macro, the glitches corrupt the period as expected.

Source files
------------

// File: rtl/pwm_pkg.sv
// Shared types for the pwm block family (pwm core and pwm_capture).
//   cap_state_e : capture FSM states
//   cnt_t       : default-width period/high counter type
//   CNT_MAX     : saturation value of a default-width counter
package pwm_pkg;

  localparam int CNT_W_DEF = 32;

  typedef logic [CNT_W_DEF-1:0] cnt_t;

  localparam cnt_t CNT_MAX = '1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2
  } cap_state_e;

endpackage

// File: rtl/pwm_capture_ch.sv
// One PWM capture channel: synchroniser, optional glitch filter, edge
// detector and a period/high-time measurement FSM.
// Optional feature macro: PWM_CAPTURE_FILTER_EN (glitch filter after sync).
// Ports:
//   clk_i      : system clock
//   rst_i      : synchronous reset, active-high
//   in_i       : asynchronous pad read-back bit
//   enable_i   : capture enable; low forces IDLE and clears the counter
//   period_o   : last period, rising edge to rising edge, in clk_i cycles
//   high_o     : high time belonging to that period
//   valid_o    : one-cycle strobe when period_o/high_o are updated
//   overflow_o : sticky, counter saturated without a rising edge
module pwm_capture_ch
  import pwm_pkg::*;
#(
  parameter int CNT_W       = CNT_W_DEF,
  parameter int SYNC_STAGES = 2,
  parameter int FILTER_LEN  = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             in_i,
  input  logic             enable_i,
  output logic [CNT_W-1:0] period_o,
  output logic [CNT_W-1:0] high_o,
  output logic             valid_o,
  output logic             overflow_o
);

  if (SYNC_STAGES < 2 || FILTER_LEN < 1) begin : g_bad_param
    $error("pwm_capture_ch: SYNC_STAGES must be >= 2 and FILTER_LEN >= 1");
  end

  localparam logic [CNT_W-1:0] CNT_SAT = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  // Saturating increment; the FSM checks for CNT_SAT separately to flag overflow.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_SAT) ? v : v + CNT_ONE;
  endfunction

  // Stage p0: input synchroniser
  logic [SYNC_STAGES-1:0] sync_p0;
  logic                   lvl;

  always_ff @(posedge clk_i) begin
    if (rst_i) sync_p0 <= '0;
    else       sync_p0 <= {sync_p0[SYNC_STAGES-2:0], in_i};
  end

  // Stage p1: glitch filter (level follows only after FILTER_LEN stable cycles)
`ifdef PWM_CAPTURE_FILTER_EN
  localparam int STAB_W = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
  localparam logic [STAB_W-1:0] STAB_LAST = STAB_W'(FILTER_LEN - 1);
  localparam logic [STAB_W-1:0] STAB_ONE  = STAB_W'(1);

  logic [STAB_W-1:0] stab_p1;
  logic              filt_p1;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stab_p1 <= '0;
      filt_p1 <= 1'b0;
    end else if (sync_p0[SYNC_STAGES-1] == filt_p1) begin
      stab_p1 <= '0;
    end else if (stab_p1 == STAB_LAST) begin
      filt_p1 <= sync_p0[SYNC_STAGES-1];
      stab_p1 <= '0;
    end else begin
      stab_p1 <= stab_p1 + STAB_ONE;
    end
  end

  assign lvl = filt_p1;
`else
  assign lvl = sync_p0[SYNC_STAGES-1];
`endif

  // Stage p2: registered edge detection
  logic lvl_p2;
  logic rise_p2;
  logic fall_p2;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      lvl_p2  <= 1'b0;
      rise_p2 <= 1'b0;
      fall_p2 <= 1'b0;
    end else begin
      lvl_p2  <= lvl;
      rise_p2 <= lvl & ~lvl_p2;
      fall_p2 <= ~lvl & lvl_p2;
    end
  end

  // Stage p3: measurement FSM and result registers
  cap_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] hold_q, hold_d;
  logic [CNT_W-1:0] period_d, high_d;
  logic             valid_d, overflow_d;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    hold_d     = hold_q;
    period_d   = period_o;
    high_d     = high_o;
    valid_d    = 1'b0;
    overflow_d = overflow_o;
    if (!enable_i) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          // First rising edge only arms the measurement.
          if (rise_p2) begin
            state_d = HIGH;
            cnt_d   = CNT_ONE;
          end
        end
        HIGH: begin
          // An edge takes priority over saturation in the same cycle.
          if (fall_p2) begin
            hold_d  = cnt_q;
            cnt_d   = sat_inc(cnt_q);
            state_d = LOW;
          end else if (cnt_q == CNT_SAT) begin
            overflow_d = 1'b1;
            cnt_d      = '0;
            state_d    = IDLE;
          end else begin
            cnt_d = sat_inc(cnt_q);
          end
        end
        LOW: begin
          if (rise_p2) begin
            period_d   = cnt_q;
            high_d     = hold_q;
            valid_d    = 1'b1;
            overflow_d = 1'b0;
            cnt_d      = CNT_ONE;
            state_d    = HIGH;
          end else if (cnt_q == CNT_SAT) begin
            overflow_d = 1'b1;
            cnt_d      = '0;
            state_d    = IDLE;
          end else begin
            cnt_d = sat_inc(cnt_q);
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      hold_q     <= '0;
      period_o   <= '0;
      high_o     <= '0;
      valid_o    <= 1'b0;
      overflow_o <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      hold_q     <= hold_d;
      period_o   <= period_d;
      high_o     <= high_d;
      valid_o    <= valid_d;
      overflow_o <= overflow_d;
    end
  end

endmodule

// File: rtl/pwm_capture.sv
// Multi-channel PWM input capture: measures period and high time of each
// pad read-back waveform in clk_i cycles. One pwm_capture_ch per channel.
// Optional feature macro: PWM_CAPTURE_FILTER_EN (per-channel glitch filter).
// Ports:
//   clk_i      : system clock
//   rst_i      : synchronous reset, active-high
//   in_i       : asynchronous pad read-back bits, one per channel
//   enable_i   : per-channel capture enable
//   period_o   : per-channel last period
//   high_o     : per-channel high time of that period
//   valid_o    : per-channel one-cycle result strobe
//   overflow_o : per-channel sticky saturation flag
module pwm_capture
  import pwm_pkg::*;
#(
  parameter int NUM_CH      = 3,
  parameter int CNT_W       = CNT_W_DEF,
  parameter int SYNC_STAGES = 2,
  parameter int FILTER_LEN  = 4
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic [NUM_CH-1:0]            in_i,
  input  logic [NUM_CH-1:0]            enable_i,
  output logic [NUM_CH-1:0][CNT_W-1:0] period_o,
  output logic [NUM_CH-1:0][CNT_W-1:0] high_o,
  output logic [NUM_CH-1:0]            valid_o,
  output logic [NUM_CH-1:0]            overflow_o
);

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    pwm_capture_ch #(
      .CNT_W       (CNT_W),
      .SYNC_STAGES (SYNC_STAGES),
      .FILTER_LEN  (FILTER_LEN)
    ) u_ch (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .in_i       (in_i[g]),
      .enable_i   (enable_i[g]),
      .period_o   (period_o[g]),
      .high_o     (high_o[g]),
      .valid_o    (valid_o[g]),
      .overflow_o (overflow_o[g])
    );
  end

endmodule

// File: tb/tb_pwm_capture.sv
// Bench for pwm_capture: a 32-bit and an 8-bit instance share the stimulus.
// A timestamp-based reference model predicts every output on every cycle;
// literal expectations pin the model at the end of each scenario.
module tb_pwm_capture;

  localparam int NCH  = 3;
  localparam int SYNC = 2;
  localparam int FLEN = 4;
`ifdef PWM_CAPTURE_FILTER_EN
  localparam int LB  = SYNC + 2;
  localparam int WIN = FLEN;
`else
  localparam int LB  = SYNC + 1;
  localparam int WIN = 1;
`endif

  logic                 clk;
  logic                 rst;
  logic [NCH-1:0]       in_sig;
  logic [NCH-1:0]       en;
  logic [NCH-1:0][31:0] p32, h32;
  logic [NCH-1:0]       v32, o32;
  logic [NCH-1:0][7:0]  p8, h8;
  logic [NCH-1:0]       v8, o8;

  pwm_capture #(.NUM_CH(NCH), .CNT_W(32), .SYNC_STAGES(SYNC), .FILTER_LEN(FLEN)) dut (
    .clk_i(clk), .rst_i(rst), .in_i(in_sig), .enable_i(en),
    .period_o(p32), .high_o(h32), .valid_o(v32), .overflow_o(o32)
  );

  pwm_capture #(.NUM_CH(NCH), .CNT_W(8), .SYNC_STAGES(SYNC), .FILTER_LEN(FLEN)) dut8 (
    .clk_i(clk), .rst_i(rst), .in_i(in_sig), .enable_i(en),
    .period_o(p8), .high_o(h8), .valid_o(v8), .overflow_o(o8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input longint act, input longint exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0d, expected %0d", nm, $time, act, exp);
    end
  endtask

  // Reference model: level history, then measurement by timestamps.
  bit     xh [NCH][WIN];
  bit     yh [NCH][LB+2];
  bit     en_edge [NCH];
  bit     m_arm [2][NCH];
  bit     m_val [2][NCH];
  bit     m_ovf [2][NCH];
  longint m_tr  [2][NCH];
  longint m_hq  [2][NCH];
  longint m_per [2][NCH];
  longint m_hi  [2][NCH];
  longint cyc = 0;

  initial begin : model
    bit     cur, prv, rise, fall, same, ynew;
    longint lim;
    forever begin
      @(posedge clk);
      cyc++;
      for (int ch = 0; ch < NCH; ch++) begin
        en_edge[ch] = en[ch];
        if (rst) begin
          for (int k = 0; k < WIN; k++) xh[ch][k] = 1'b0;
          for (int k = 0; k < LB + 2; k++) yh[ch][k] = 1'b0;
        end else begin
          for (int k = WIN - 1; k > 0; k--) xh[ch][k] = xh[ch][k-1];
          xh[ch][0] = in_sig[ch];
          same = 1'b1;
          for (int k = 0; k < WIN; k++) if (xh[ch][k] != xh[ch][0]) same = 1'b0;
          ynew = same ? xh[ch][0] : yh[ch][0];
          for (int k = LB + 1; k > 0; k--) yh[ch][k] = yh[ch][k-1];
          yh[ch][0] = ynew;
        end
        cur  = yh[ch][LB];
        prv  = yh[ch][LB+1];
        rise = cur & !prv;
        fall = !cur & prv;
        for (int i = 0; i < 2; i++) begin
          lim = (i == 0) ? 64'd4294967295 : 64'd255;
          if (rst) begin
            m_arm[i][ch] = 0; m_val[i][ch] = 0; m_ovf[i][ch] = 0;
            m_per[i][ch] = 0; m_hi[i][ch] = 0; m_hq[i][ch] = 0; m_tr[i][ch] = 0;
          end else if (!en[ch]) begin
            m_arm[i][ch] = 0; m_val[i][ch] = 0;
          end else begin
            m_val[i][ch] = 0;
            if (!m_arm[i][ch]) begin
              if (rise) begin m_arm[i][ch] = 1; m_tr[i][ch] = cyc; end
            end else if (rise) begin
              m_per[i][ch] = cyc - m_tr[i][ch];
              m_hi[i][ch]  = m_hq[i][ch];
              m_val[i][ch] = 1;
              m_ovf[i][ch] = 0;
              m_tr[i][ch]  = cyc;
            end else if (fall) begin
              m_hq[i][ch] = cyc - m_tr[i][ch];
            end else if (cyc - m_tr[i][ch] >= lim) begin
              m_ovf[i][ch] = 1;
              m_arm[i][ch] = 0;
            end
          end
        end
      end
    end
  end

  int vcnt32 [NCH];
  int vcnt8  [NCH];
  int dis_valid = 0;

  initial begin : compare
    @(posedge clk);
    forever begin
      @(negedge clk);
      for (int ch = 0; ch < NCH; ch++) begin
        chk($sformatf("valid32[%0d]", ch), v32[ch], m_val[0][ch]);
        chk($sformatf("ovf32[%0d]", ch), o32[ch], m_ovf[0][ch]);
        chk($sformatf("period32[%0d]", ch), p32[ch], m_per[0][ch]);
        chk($sformatf("high32[%0d]", ch), h32[ch], m_hi[0][ch]);
        chk($sformatf("valid8[%0d]", ch), v8[ch], m_val[1][ch]);
        chk($sformatf("ovf8[%0d]", ch), o8[ch], m_ovf[1][ch]);
        chk($sformatf("period8[%0d]", ch), p8[ch], m_per[1][ch]);
        chk($sformatf("high8[%0d]", ch), h8[ch], m_hi[1][ch]);
        if (v32[ch]) vcnt32[ch]++;
        if (v8[ch]) vcnt8[ch]++;
        if (!en_edge[ch] && v32[ch]) dis_valid++;
      end
    end
  end

  task automatic step(input logic [NCH-1:0] lv);
    in_sig = lv;
    @(negedge clk);
    #1;
  endtask

  initial begin : stim
    int  base;
    int  duty [NCH];
    bit  l0, l1, l2;
    rst = 1'b1; en = '0; in_sig = '0;
    repeat (3) @(negedge clk);
    #1;
    for (int ch = 0; ch < NCH; ch++) begin
      chk("reset_period32", p32[ch], 0);
      chk("reset_high32", h32[ch], 0);
      chk("reset_valid32", v32[ch], 0);
      chk("reset_ovf8", o8[ch], 0);
    end
    rst = 1'b0; en = '1;

    // ch0: 32 high / 224 low; ch1 stuck high
    for (int c = 0; c < 4 * 256; c++) step({1'b0, 1'b1, (c % 256) < 32});
    repeat (10) step(3'b010);
    chk("t1_period", p32[0], 256);
    chk("t1_high", h32[0], 32);
    chk("t1_valids", vcnt32[0], 3);
    chk("t2_ovf8_stuck", o8[1], 1);
    chk("t2_valid8_stuck", vcnt8[1], 0);
    chk("t2_ovf32_stuck", o32[1], 0);

    // ch1: 10 high / 20 low after the stuck-high level
    base = vcnt8[1];
    for (int c = 0; c < 170; c++) step({1'b0, (c >= 20) && ((c - 20) % 30 < 10), 1'b0});
    repeat (10) step(3'b000);
    chk("t2_ovf8_cleared", o8[1], 0);
    chk("t2_period8", p8[1], 30);
    chk("t2_high8", h8[1], 10);
    chk("t2_valids8", vcnt8[1] - base, 4);

    // ch2: 15 high / 25 low, disabled for 50 cycles mid-period
    base = vcnt32[2];
    for (int c = 0; c < 360; c++) begin
      en[2] = !(c >= 130 && c < 180);
      step({(c % 40) < 15, 1'b0, 1'b0});
    end
    en = '1;
    repeat (10) step(3'b000);
    chk("t3_valids", vcnt32[2] - base, 6);
    chk("t3_disabled_valids", dis_valid, 0);
    chk("t3_period", p32[2], 40);
    chk("t3_high", h32[2], 15);

    // ch0: reset during the high phase of a 20/20 waveform
    for (int c = 0; c < 286; c++) begin
      rst = (c == 85);
      step({1'b0, 1'b0, (c % 40) < 20});
      if (c == 85) begin
        for (int ch = 0; ch < NCH; ch++) begin
          chk("t4_rst_period32", p32[ch], 0);
          chk("t4_rst_ovf8", o8[ch], 0);
          chk("t4_rst_valid32", v32[ch], 0);
        end
      end
    end
    rst = 1'b0;
    chk("t4_period", p32[0], 40);
    chk("t4_high", h32[0], 20);

    // pwm loop-back pattern: period 255, duty 32/64/5
    duty[0] = 32; duty[1] = 64; duty[2] = 5;
    for (int c = 0; c < 1020; c++) begin
      l0 = (c % 255) < duty[0];
      l1 = (c % 255) < duty[1];
      l2 = (c % 255) < duty[2];
      step({l2, l1, l0});
    end
    for (int ch = 0; ch < NCH; ch++) begin
      chk("t5_period32", p32[ch], 255);
      chk("t5_high32", h32[ch], duty[ch]);
      chk("t5_period8_at_max", p8[ch], 255);
      chk("t5_ovf8_edge_wins", o8[ch], 0);
    end

    // ch0: 20/20 waveform with a 2-cycle high glitch in a low phase
    // and a 2-cycle low glitch in the following high phase
    for (int c = 0; c < 240; c++) begin
      l0 = (c % 40) < 20;
      if (c == 148 || c == 149) l0 = 1'b1;
      if (c == 168 || c == 169) l0 = 1'b0;
      step({1'b0, 1'b0, l0});
    end
`ifdef PWM_CAPTURE_FILTER_EN
    chk("t6_period_filtered", p32[0], 40);
    chk("t6_high_filtered", h32[0], 20);
`else
    chk("t6_period_glitched", p32[0], 30);
    chk("t6_high_glitched", h32[0], 10);
`endif
    repeat (5) step(3'b000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
